rc4_key_sched: RTL and testbench

Top-level sequencer and S-memory arbiter for the RC4 brute-force key search. It iterates a secret key over a range and, for each key, runs three tasks in order: S-init (task1), KSA (task2a) and PRGA decrypt (task2b). It grants the single-port s_memory to exactly one task at a time and screens every decrypted byte. It stops on the first key whose plaintext is all lowercase/space, or when the range is exhausted.

---
 rtl/rc4_key_sched.sv | 189 ++++++++++++++++++
 tb/tb_rc4_key_sched.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_key_sched.sv
// rc4_key_sched: key-range sequencer for the RC4 brute-force search.
// Runs task1 / task2a / task2b per key and owns the single s_memory port.
module rc4_key_sched #(
    parameter int KEY_W   = 24,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [KEY_W-1:0] key_lo,
    input  logic [KEY_W-1:0] key_hi,
    input  logic             t1_fin,
    input  logic             t2a_fin,
    input  logic             t2b_fin,
    output logic             t1_start,
    output logic             t2a_start,
    output logic             t2b_start,
    input  logic [7:0]       t1_addr,
    input  logic [7:0]       t1_data,
    input  logic [7:0]       t2a_addr,
    input  logic [7:0]       t2a_data,
    input  logic [7:0]       t2b_addr,
    input  logic [7:0]       t2b_data,
    input  logic             t1_wr_en,
    input  logic             t2a_wr_en,
    input  logic             t2b_wr_en,
    output logic [7:0]       s_addr,
    output logic [7:0]       s_data,
    output logic             s_wr_en,
    input  logic             dec_wr_en,
    input  logic [7:0]       dec_data,
    output logic [KEY_W-1:0] secret_key,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic             err,
    output logic [KEY_W-1:0] key_found
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_KSA,
        S_PRGA,
        S_CHECK,
        S_FOUND,
        S_EXH
    } state_t;

    state_t           state;
    logic [KEY_W-1:0] key;
    logic [KEY_W-1:0] key_last;
    logic [7:0]       byte_cnt;
    logic             bad;
    logic [WD_W-1:0]  wdog;
    logic             wr_viol;
    logic             dec_ok;
    logic             wd_hit;

    assign secret_key = key;
    assign busy = (state == S_T1) || (state == S_KSA) ||
                  (state == S_PRGA) || (state == S_CHECK);

    assign dec_ok = ((dec_data >= 8'h61) && (dec_data <= 8'h7A)) ||
                    (dec_data == 8'h20);
    assign wd_hit = (wdog == WD_W'(TIMEOUT - 1));

    // Any write from a task that does not own the port is a protocol error.
    assign wr_viol = (t1_wr_en  && (state != S_T1))  ||
                     (t2a_wr_en && (state != S_KSA)) ||
                     (t2b_wr_en && (state != S_PRGA));

    always_comb begin
        s_addr  = 8'h00;
        s_data  = 8'h00;
        s_wr_en = 1'b0;
        unique case (state)
            S_T1: begin
                s_addr  = t1_addr;
                s_data  = t1_data;
                s_wr_en = t1_wr_en;
            end
            S_KSA: begin
                s_addr  = t2a_addr;
                s_data  = t2a_data;
                s_wr_en = t2a_wr_en;
            end
            S_PRGA: begin
                s_addr  = t2b_addr;
                s_data  = t2b_data;
                s_wr_en = t2b_wr_en;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            key       <= '0;
            key_last  <= '0;
            key_found <= '0;
            byte_cnt  <= 8'h00;
            bad       <= 1'b0;
            wdog      <= '0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            err       <= 1'b0;
            t1_start  <= 1'b0;
            t2a_start <= 1'b0;
            t2b_start <= 1'b0;
        end else begin
            t1_start  <= 1'b0;
            t2a_start <= 1'b0;
            t2b_start <= 1'b0;
            if (wr_viol) err <= 1'b1;
            if ((state == S_PRGA) && dec_wr_en) begin
                if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
                if (!dec_ok) bad <= 1'b1;
            end
            if (abort) begin
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: if (start) begin
                        key       <= key_lo;
                        key_last  <= key_hi;
                        found     <= 1'b0;
                        exhausted <= 1'b0;
                        err       <= 1'b0;
                        bad       <= 1'b0;
                        byte_cnt  <= 8'h00;
                        wdog      <= '0;
                        t1_start  <= 1'b1;
                        state     <= S_T1;
                    end
                    S_T1: if (t1_fin) begin
                        wdog      <= '0;
                        t2a_start <= 1'b1;
                        state     <= S_KSA;
                    end else if (wd_hit) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                    S_KSA: if (t2a_fin) begin
                        wdog      <= '0;
                        t2b_start <= 1'b1;
                        state     <= S_PRGA;
                    end else if (wd_hit) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                    S_PRGA: if (t2b_fin) begin
                        state <= S_CHECK;
                    end else if (wd_hit) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                    S_CHECK: if (!bad && (byte_cnt != 8'h00)) begin
                        found     <= 1'b1;
                        key_found <= key;
                        state     <= S_FOUND;
                    end else if (key == key_last) begin
                        exhausted <= 1'b1;
                        state     <= S_EXH;
                    end else begin
                        key      <= key + 1'b1;
                        bad      <= 1'b0;
                        byte_cnt <= 8'h00;
                        wdog     <= '0;
                        t1_start <= 1'b1;
                        state    <= S_T1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rc4_key_sched.sv
// Directed bench for rc4_key_sched: the bench plays the three tasks
// and checks sequencing, screening, arbitration, watchdog and abort.
module tb_rc4_key_sched;

    localparam int TO = 48;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [23:0] key_lo;
    logic [23:0] key_hi;
    logic        t1_fin;
    logic        t2a_fin;
    logic        t2b_fin;
    logic        t1_start;
    logic        t2a_start;
    logic        t2b_start;
    logic [7:0]  t1_addr;
    logic [7:0]  t1_data;
    logic [7:0]  t2a_addr;
    logic [7:0]  t2a_data;
    logic [7:0]  t2b_addr;
    logic [7:0]  t2b_data;
    logic        t1_wr_en;
    logic        t2a_wr_en;
    logic        t2b_wr_en;
    logic [7:0]  s_addr;
    logic [7:0]  s_data;
    logic        s_wr_en;
    logic        dec_wr_en;
    logic [7:0]  dec_data;
    logic [23:0] secret_key;
    logic        busy;
    logic        found;
    logic        exhausted;
    logic        err;
    logic [23:0] key_found;

    int n_chk;
    int n_fail;
    int n_t1;
    int n_t2a;
    int n_t2b;
    logic [23:0] keys_seen [8];

    rc4_key_sched #(.KEY_W(24), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .key_lo(key_lo), .key_hi(key_hi),
        .t1_fin(t1_fin), .t2a_fin(t2a_fin), .t2b_fin(t2b_fin),
        .t1_start(t1_start), .t2a_start(t2a_start), .t2b_start(t2b_start),
        .t1_addr(t1_addr), .t1_data(t1_data),
        .t2a_addr(t2a_addr), .t2a_data(t2a_data),
        .t2b_addr(t2b_addr), .t2b_data(t2b_data),
        .t1_wr_en(t1_wr_en), .t2a_wr_en(t2a_wr_en), .t2b_wr_en(t2b_wr_en),
        .s_addr(s_addr), .s_data(s_data), .s_wr_en(s_wr_en),
        .dec_wr_en(dec_wr_en), .dec_data(dec_data),
        .secret_key(secret_key), .busy(busy), .found(found),
        .exhausted(exhausted), .err(err), .key_found(key_found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] clean_byte(input int i);
        logic [7:0] b;
        if (i % 27 == 26) b = 8'h20;
        else b = 8'h61 + 8'(i % 27);
        return b;
    endfunction

    task automatic wait_strobe(input int sel);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            case (sel)
                0: hit = t1_start;
                1: hit = t2a_start;
                default: hit = t2b_start;
            endcase
            if (!hit) tick();
        end
        chk($sformatf("strobe_wait_%0d", sel), {31'd0, hit}, 1);
        if (hit) begin
            case (sel)
                0: begin
                    if (n_t1 < 8) keys_seen[n_t1] = secret_key;
                    n_t1++;
                end
                1: n_t2a++;
                default: n_t2b++;
            endcase
        end
    endtask

    task automatic do_start(input logic [23:0] lo, input logic [23:0] hi);
        key_lo = lo;
        key_hi = hi;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic clear_counts();
        n_t1  = 0;
        n_t2a = 0;
        n_t2b = 0;
    endtask

    // One full key: T1, KSA, then nbytes plaintext bytes with an optional bad one.
    task automatic run_key(input logic [7:0] bad_byte, input int bad_at,
                           input int nbytes);
        logic [23:0] k;
        wait_strobe(0);
        k = secret_key;
        t1_fin = 1'b1;
        tick();
        t1_fin = 1'b0;
        wait_strobe(1);
        t2a_fin = 1'b1;
        tick();
        t2a_fin = 1'b0;
        wait_strobe(2);
        for (int i = 0; i < nbytes; i++) begin
            dec_wr_en = 1'b1;
            dec_data  = (i == bad_at) ? bad_byte : clean_byte(i);
            tick();
        end
        dec_wr_en = 1'b0;
        dec_data  = 8'h00;
        chk("key_stable", {8'd0, secret_key}, {8'd0, k});
        t2b_fin = 1'b1;
        tick();
        t2b_fin = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        clear_counts();
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        key_lo = '0;
        key_hi = '0;
        t1_fin = 1'b0;
        t2a_fin = 1'b0;
        t2b_fin = 1'b0;
        t1_addr = '0;
        t1_data = '0;
        t2a_addr = '0;
        t2a_data = '0;
        t2b_addr = '0;
        t2b_data = '0;
        t1_wr_en = 1'b0;
        t2a_wr_en = 1'b0;
        t2b_wr_en = 1'b0;
        dec_wr_en = 1'b0;
        dec_data = '0;
        repeat (3) tick();

        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_flags", {29'd0, found, exhausted, err}, 0);
        chk("rst_strobes", {29'd0, t1_start, t2a_start, t2b_start}, 0);
        chk("rst_key", {8'd0, secret_key}, 0);
        chk("rst_key_found", {8'd0, key_found}, 0);
        rst = 1'b1;
        tick();
        t1_addr = 8'h55;
        t1_data = 8'hAA;
        #1;
        chk("idle_mux", {15'd0, s_wr_en, s_addr, s_data}, 0);
        t1_addr = '0;
        t1_data = '0;

        // single clean key
        do_start(24'h000249, 24'h000249);
        run_key(8'h00, -1, 32);
        tick();
        chk("t1_found", {31'd0, found}, 1);
        chk("t1_key_found", {8'd0, key_found}, 32'h249);
        chk("t1_busy", {31'd0, busy}, 0);
        chk("t1_err", {31'd0, err}, 0);
        chk("t1_exh", {31'd0, exhausted}, 0);
        chk("t1_pulses", n_t1 * 100 + n_t2a * 10 + n_t2b, 111);
        repeat (3) tick();
        chk("t1_quiet", {29'd0, t1_start, t2a_start, t2b_start}, 0);
        do_abort();
        chk("abort_keeps_found", {31'd0, found}, 1);

        // two dirty keys then a clean one
        clear_counts();
        do_start(24'd0, 24'd2);
        chk("t2_found_clr", {31'd0, found}, 0);
        run_key(8'h07, 5, 32);
        run_key(8'h07, 0, 32);
        run_key(8'h00, -1, 32);
        tick();
        chk("t2_found", {31'd0, found}, 1);
        chk("t2_key_found", {8'd0, key_found}, 2);
        chk("t2_t1_cnt", n_t1, 3);
        chk("t2_key0", {8'd0, keys_seen[0]}, 0);
        chk("t2_key1", {8'd0, keys_seen[1]}, 1);
        chk("t2_key2", {8'd0, keys_seen[2]}, 2);
        do_abort();

        // every key dirty -> exhausted
        clear_counts();
        do_start(24'd5, 24'd6);
        run_key(8'hFF, 2, 32);
        run_key(8'hFF, 31, 32);
        tick();
        chk("t3_exh", {31'd0, exhausted}, 1);
        chk("t3_found", {31'd0, found}, 0);
        chk("t3_key", {8'd0, secret_key}, 6);
        chk("t3_busy", {31'd0, busy}, 0);
        repeat (3) tick();
        chk("t3_t1_cnt", n_t1 + (t1_start ? 1 : 0), 2);
        do_abort();

        // empty plaintext and bytes just outside the lowercase range
        do_start(24'd8, 24'd10);
        run_key(8'h00, -1, 0);
        run_key(8'h7B, 4, 32);
        run_key(8'h60, 10, 20);
        tick();
        chk("t3b_exh", {31'd0, exhausted}, 1);
        chk("t3b_found", {31'd0, found}, 0);
        chk("t3b_key", {8'd0, secret_key}, 10);
        do_abort();

        // arbitration, misrouted fin strobes and stray writes
        do_start(24'd3, 24'd3);
        wait_strobe(0);
        t1_addr = 8'h12;
        t1_data = 8'h34;
        t1_wr_en = 1'b1;
        #1;
        chk("t4_mux_t1", {15'd0, s_wr_en, s_addr, s_data}, 32'h11234);
        t1_wr_en = 1'b0;
        t2a_fin = 1'b1;
        t2b_fin = 1'b1;
        tick();
        t2a_fin = 1'b0;
        t2b_fin = 1'b0;
        chk("t4_wrong_fin", {30'd0, t2a_start, busy}, 1);
        chk("t4_err_clean", {31'd0, err}, 0);
        t1_fin = 1'b1;
        tick();
        t1_fin = 1'b0;
        wait_strobe(1);
        t2a_addr = 8'h56;
        t2a_data = 8'h78;
        t1_addr = 8'hFF;
        t1_wr_en = 1'b1;
        #1;
        chk("t4_mux_ksa", {15'd0, s_wr_en, s_addr, s_data}, 32'h05678);
        tick();
        t1_wr_en = 1'b0;
        chk("t4_err_set", {31'd0, err}, 1);
        t2a_wr_en = 1'b1;
        #1;
        chk("t4_ksa_wr", {31'd0, s_wr_en}, 1);
        t2a_wr_en = 1'b0;
        t2a_fin = 1'b1;
        tick();
        t2a_fin = 1'b0;
        wait_strobe(2);
        for (int i = 0; i < 8; i++) begin
            dec_wr_en = 1'b1;
            dec_data = clean_byte(i + 20);
            tick();
        end
        dec_wr_en = 1'b0;
        t2b_fin = 1'b1;
        tick();
        t2b_fin = 1'b0;
        tick();
        chk("t4_found", {31'd0, found}, 1);
        chk("t4_key_found", {8'd0, key_found}, 3);
        chk("t4_err_sticky", {31'd0, err}, 1);
        do_abort();

        // watchdog in KSA
        do_start(24'd1, 24'd1);
        wait_strobe(0);
        t1_fin = 1'b1;
        tick();
        t1_fin = 1'b0;
        wait_strobe(1);
        repeat (TO - 1) tick();
        chk("t5_before", {30'd0, busy, err}, 32'h2);
        tick();
        chk("t5_after", {30'd0, busy, err}, 32'h1);
        repeat (2) tick();
        chk("t5_quiet", {29'd0, t1_start, t2a_start, t2b_start}, 0);
        do_start(24'd7, 24'd7);
        chk("t5_err_clr", {31'd0, err}, 0);
        run_key(8'h00, -1, 8);
        tick();
        chk("t5_found", {31'd0, found}, 1);
        chk("t5_key_found", {8'd0, key_found}, 7);
        do_abort();

        // abort in PRGA, with a simultaneous fin
        do_start(24'd4, 24'd9);
        wait_strobe(0);
        t1_fin = 1'b1;
        tick();
        t1_fin = 1'b0;
        wait_strobe(1);
        t2a_fin = 1'b1;
        tick();
        t2a_fin = 1'b0;
        wait_strobe(2);
        repeat (3) begin
            dec_wr_en = 1'b1;
            dec_data = 8'h62;
            tick();
        end
        dec_wr_en = 1'b0;
        abort = 1'b1;
        t2b_fin = 1'b1;
        tick();
        abort = 1'b0;
        t2b_fin = 1'b0;
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_key_held", {8'd0, secret_key}, 4);
        chk("t6_flags", {30'd0, found, exhausted}, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_quiet", {28'd0, busy, t1_start, t2a_start, t2b_start}, 0);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t6_start_abort", {30'd0, busy, t1_start}, 0);

        // reset mid-T1
        do_start(24'd10, 24'd10);
        wait_strobe(0);
        chk("t7_key", {8'd0, secret_key}, 10);
        rst = 1'b0;
        #1;
        chk("t7_rst_busy", {28'd0, busy, t1_start, t2a_start, t2b_start}, 0);
        chk("t7_rst_key", {8'd0, secret_key}, 0);
        chk("t7_rst_flags", {29'd0, found, exhausted, err}, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t7_quiet", {28'd0, busy, t1_start, t2a_start, t2b_start}, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
